line_window_buffer: RTL and testbench

- Parametrised multi-line FIFO buffer for the edge-detect path.
- Delays the streaming pixel by one row for each of NUM_LINES rows, and presents a vertical column of NUM_LINES+1 taps (current row plus rows above) each accepted pixel. The downstream 3x3 Sobel window is built from this column.
- Runs on a single clock. There is no inverted write clock; each line RAM does read-before-write at the same address.
- Zero-fills taps from rows not yet received in the current frame, and flags when the window is fully primed.

---
 rtl/line_window_buffer.sv | 59 +++++
 tb/tb_line_window_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// line_window_buffer: chained one-row line delays producing a NUM_LINES+1 tap vertical column per accepted pixel.
module line_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int NO_OF_COLS = 320,
  parameter int NUM_LINES  = 2,
  parameter int COL_W      = 9
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  fsync,
  input  logic                                  rsync,
  input  logic [DATA_WIDTH-1:0]                 pdata_in,
  output logic [(NUM_LINES+1)*DATA_WIDTH-1:0]   tap_out,
  output logic                                  tap_valid,
  output logic                                  primed,
  output logic [COL_W-1:0]                      col_out
);
  localparam int RW = $clog2(NUM_LINES + 1);
  logic [DATA_WIDTH-1:0] mem [NUM_LINES][NO_OF_COLS];
  logic [COL_W-1:0] col;
  logic [RW-1:0] row;
  logic acc, last, row_end;
  assign acc = fsync && rsync;
  assign last = col == COL_W'(NO_OF_COLS - 1);
  assign row_end = acc ? last : col != '0;
  // Read-before-write: each RAM stage shifts the old value at this column one row deeper.
  always_ff @(posedge clk) begin
    if (acc && !rst) begin
      mem[0][col] <= pdata_in;
      for (int k = 1; k < NUM_LINES; k++) mem[k][col] <= mem[k-1][col];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_out   <= '0;
      tap_valid <= 1'b0;
      primed    <= 1'b0;
      col_out   <= '0;
      col       <= '0;
      row       <= '0;
    end else if (!fsync) begin
      col       <= '0;
      row       <= '0;
      tap_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      tap_valid <= acc;
      col       <= acc && !last ? col + 1'b1 : '0;
      if (row_end && row != RW'(NUM_LINES)) row <= row + 1'b1;
      if (acc) begin
        tap_out[0 +: DATA_WIDTH] <= pdata_in;
        for (int k = 1; k <= NUM_LINES; k++)
          tap_out[k*DATA_WIDTH +: DATA_WIDTH] <= row >= RW'(k) ? mem[k-1][col] : '0;
        primed  <= row == RW'(NUM_LINES);
        col_out <= col;
      end
    end
  end
endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed and random stimulus checked against a per-column pixel history model.
module tb_line_window_buffer;
  logic clk = 0, rst = 0, fsync = 0, rsync = 0;
  logic [7:0] pdata_in = 0;
  logic [23:0] tap_out;
  logic tap_valid, primed;
  logic [2:0] col_out;
  int tests = 0, fails = 0;
  logic [7:0] hist [8][$];
  int m_col = 0, m_row = 0;
  logic [23:0] e_tap = 0;
  logic e_valid = 0, e_primed = 0;
  logic [2:0] e_col = 0;

  line_window_buffer #(.DATA_WIDTH(8), .NO_OF_COLS(8), .NUM_LINES(2), .COL_W(3)) dut (
    .clk(clk), .rst(rst), .fsync(fsync), .rsync(rsync), .pdata_in(pdata_in),
    .tap_out(tap_out), .tap_valid(tap_valid), .primed(primed), .col_out(col_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic [7:0] d);
    int n;
    rst = r; fsync = f; rsync = s; pdata_in = d;
    @(posedge clk);
    if (r) begin
      m_col = 0; m_row = 0; e_tap = 0; e_valid = 0; e_primed = 0; e_col = 0;
    end else if (!f) begin
      m_col = 0; m_row = 0; e_valid = 0; e_primed = 0;
    end else if (s) begin
      n = hist[m_col].size();
      e_tap = {m_row >= 2 ? hist[m_col][n-2] : 8'h00, m_row >= 1 ? hist[m_col][n-1] : 8'h00, d};
      hist[m_col].push_back(d);
      e_col = 3'(m_col);
      e_valid = 1;
      e_primed = m_row == 2;
      if (m_col == 7) begin
        m_col = 0;
        m_row = m_row < 2 ? m_row + 1 : 2;
      end else m_col++;
    end else begin
      e_valid = 0;
      if (m_col != 0) m_row = m_row < 2 ? m_row + 1 : 2;
      m_col = 0;
    end
    #1;
    chk("tap_valid", 32'(tap_valid), 32'(e_valid));
    chk("tap_out", 32'(tap_out), 32'(e_tap));
    chk("primed", 32'(primed), 32'(e_primed));
    if (e_valid) chk("col_out", 32'(col_out), 32'(e_col));
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 1, 1, 8'hff);
    chk("reset_zero", {tap_out, 5'(0), tap_valid, primed, col_out}, 32'h0);
    step(0, 1, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        step(0, 1, 1, 8'(r*16 + c));
        if (r == 0 && c == 3) chk("row0c3", 32'(tap_out), 32'h000003);
        if (r == 1 && c == 3) chk("row1c3", 32'(tap_out), 32'h000313);
        if (r == 2 && c == 3) chk("row2c3", {7'(0), primed, tap_out}, {7'(0), 1'b1, 24'h031323});
        if (r == 3 && c == 7) chk("row3c7", 32'(tap_out), 32'h172737);
      end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("latency_idle", 32'(tap_valid), 32'h0);
    step(0, 1, 1, 8'h5a);
    chk("latency_one", {tap_valid, col_out}, {1'b1, 3'd0});
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        step(0, 1, 1, 8'($urandom));
        if (c == 0) chk("short_col0", 32'(col_out), 32'h0);
        if (c == 0) chk("short_primed", 32'(primed), 32'(r >= 2));
      end
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 1, 8'($urandom));
    step(0, 0, 1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 8'($urandom));
      if (i == 0) chk("gap_restart", {primed, col_out, tap_out[23:8]}, 32'h0);
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 28; i++) step(0, 1, 1, 8'($urandom));
    step(1, 1, 1, 8'h99);
    chk("rst_mid", {tap_out, 5'(0), tap_valid, primed, col_out}, 32'h0);
    step(0, 1, 1, 8'h42);
    chk("rst_next", {primed, col_out, tap_out}, {1'b0, 3'd0, 24'h000042});
    step(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, 1, 8'($urandom));
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 8'($urandom));
      chk("stale_mask", 32'(tap_out[23:8]), 32'h0);
    end
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 4) != 0, 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
